fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 18 +
 rtl/fetch_unit_if_id_reg.sv | 34 +++
 rtl/fetch_unit.sv | 64 ++++++
 tb/tb_fetch_unit.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch stage.
package fetch_unit_pkg;
  localparam int          INSTR_W      = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_INC       = 32'd4;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc4;
    logic               valid;
  } ifid_t;

  // Low two bits of a byte target must be zero for word-aligned fetch.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return |addr[1:0];
  endfunction
endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: bubble wins over load, neither means hold.
module if_id_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP_WORD = NOP_WORD_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               bubble,
  input  logic [INSTR_W-1:0] instr,
  input  logic [31:0]        pc4,
  output ifid_t              o_q
);
  ifid_t r_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q.instr <= NOP_WORD;
      r_q.pc4   <= '0;
      r_q.valid <= 1'b0;
    end else if (bubble) begin
      r_q.instr <= NOP_WORD;
      r_q.pc4   <= '0;
      r_q.valid <= 1'b0;
    end else if (load) begin
      r_q.instr <= instr;
      r_q.pc4   <= pc4;
      r_q.valid <= 1'b1;
    end
  end

  assign o_q = r_q;
endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, redirect/stall control, IF/ID latch and fetch counter.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0]        RESET_PC = RESET_PC_DEF,
  parameter logic [INSTR_W-1:0] NOP_WORD = NOP_WORD_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic [31:0]        imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [31:0]        ifid_pc4,
  output logic               ifid_valid,
  output logic               misalign_err,
  output logic [31:0]        fetch_count
);
  logic [31:0] r_pc;
  logic        r_misalign;
  logic [31:0] r_fetch_count;
  logic [31:0] w_pc4;
  logic        w_advance;
  ifid_t       w_ifid;

  assign w_pc4     = r_pc + PC_INC;
  assign w_advance = !redirect_valid && !stall;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc          <= RESET_PC;
      r_misalign    <= 1'b0;
      r_fetch_count <= '0;
    end else begin
      // Redirect overrides stall; the target is forced word-aligned.
      if (redirect_valid)
        r_pc <= {redirect_pc[31:2], 2'b00};
      else if (!stall)
        r_pc <= w_pc4;
      r_misalign <= redirect_valid && is_misaligned(redirect_pc);
      if (w_advance)
        r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  if_id_reg #(.NOP_WORD(NOP_WORD)) u_if_id (
    .clk    (clk),
    .rst    (rst),
    .load   (w_advance),
    .bubble (redirect_valid),
    .instr  (imem_data),
    .pc4    (w_pc4),
    .o_q    (w_ifid)
  );

  assign imem_addr    = r_pc;
  assign ifid_instr   = w_ifid.instr;
  assign ifid_pc4     = w_ifid.pc4;
  assign ifid_valid   = w_ifid.valid;
  assign misalign_err = r_misalign;
  assign fetch_count  = r_fetch_count;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a combinational word-addressed instruction memory.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic        misalign_err;
  logic [31:0] fetch_count;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [0:63];

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr[7:2]];

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .ifid_instr     (ifid_instr),
    .ifid_pc4       (ifid_pc4),
    .ifid_valid     (ifid_valid),
    .misalign_err   (misalign_err),
    .fetch_count    (fetch_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] ins, input logic [31:0] p4,
                          input logic v, input logic [31:0] cnt);
    chk({tag, "_instr"}, ifid_instr, ins);
    chk({tag, "_pc4"}, ifid_pc4, p4);
    chk({tag, "_valid"}, {31'd0, ifid_valid}, {31'd0, v});
    chk({tag, "_count"}, fetch_count, cnt);
  endtask

  initial begin
    // Word i holds 0x11*(i+1): 0x11,0x22,0x33,0x44 ... mem[16]=0x121, mem[63]=0x440
    for (int i = 0; i < 64; i++) mem[i] = 32'h11 * (i + 1);

    rst = 1'b0; stall = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0042;
    step(); step();
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_mis", {31'd0, misalign_err}, 32'h0);
    chk_ifid("rst", 32'h0, 32'h0, 1'b0, 32'h0);

    // Four free-run edges
    redirect_valid = 1'b0; redirect_pc = 32'h0; rst = 1'b1;
    step(); chk_ifid("run1", 32'h11, 32'd4, 1'b1, 32'd1);
    step(); chk_ifid("run2", 32'h22, 32'd8, 1'b1, 32'd2);
    step(); chk_ifid("run3", 32'h33, 32'd12, 1'b1, 32'd3);
    step(); chk_ifid("run4", 32'h44, 32'd16, 1'b1, 32'd4);
    chk("run4_addr", imem_addr, 32'd16);

    // Reset, advance to PC=8, then stall three cycles
    rst = 1'b0; step(); rst = 1'b1;
    step(); step();
    chk("pre_stall_addr", imem_addr, 32'd8);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_addr", imem_addr, 32'd8);
      chk_ifid("stall", 32'h22, 32'd8, 1'b1, 32'd2);
    end
    stall = 1'b0;
    step(); chk_ifid("resume", 32'h33, 32'd12, 1'b1, 32'd3);
    chk("resume_addr", imem_addr, 32'd12);

    // Redirect with simultaneous stall
    redirect_valid = 1'b1; redirect_pc = 32'h40; stall = 1'b1;
    step();
    chk("redir_addr", imem_addr, 32'h40);
    chk("redir_mis", {31'd0, misalign_err}, 32'h0);
    chk_ifid("redir_bub", 32'h0, 32'h0, 1'b0, 32'd3);
    redirect_valid = 1'b0; stall = 1'b0;
    step(); chk_ifid("redir_tgt", 32'h121, 32'h44, 1'b1, 32'd4);

    // Misaligned redirect
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    step();
    chk("mis_addr", imem_addr, 32'h40);
    chk("mis_pulse", {31'd0, misalign_err}, 32'h1);
    redirect_valid = 1'b0;
    step();
    chk("mis_clear", {31'd0, misalign_err}, 32'h0);
    chk_ifid("mis_tgt", 32'h121, 32'h44, 1'b1, 32'd5);

    // Wrap at top of address space
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    chk("wrap_pc", imem_addr, 32'hFFFF_FFFC);
    redirect_valid = 1'b0;
    step();
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_mis", {31'd0, misalign_err}, 32'h0);
    chk_ifid("wrap", 32'h440, 32'h0, 1'b1, 32'd6);

    // Reset while stalled at PC=0x20
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    step();
    redirect_valid = 1'b0; stall = 1'b1;
    step();
    chk("pre_rst_addr", imem_addr, 32'h20);
    chk("bubble_hold_cnt", fetch_count, 32'd6);
    rst = 1'b0;
    step();
    chk("mrst_addr", imem_addr, 32'h0);
    chk_ifid("mrst", 32'h0, 32'h0, 1'b0, 32'h0);
    rst = 1'b1;
    step();
    chk("post_rst_stall_addr", imem_addr, 32'h0);
    stall = 1'b0;
    step();
    chk_ifid("post_rst", 32'h11, 32'd4, 1'b1, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
